axi_ram_slave: RTL and testbench

- Memory-mapped AXI-lite responder that terminates one `axi_intf` slave port of the interconnect.
- Provides word-addressed on-chip RAM for instruction/data storage.
- Accepts writes with byte strobes and returns reads with fixed single-cycle latency.
- Uses the same reduced channel set as `axi_intf`: AW, W and R. There is no B channel, no AR ready and no response codes.

---
 rtl/axi_ram_slave_pkg.sv | 13 +
 rtl/axi_ram_slave_if.sv | 32 +++
 rtl/axi_ram_slave_ram_1r1w.sv | 55 +++++
 rtl/axi_ram_slave.sv | 114 +++++++++++
 tb/tb_axi_ram_slave.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI-lite widths and the read-channel state type for the RAM responder.
package axi_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_ram_slave_if.sv
// Reduced AXI-lite channel bundle (AW, W, R only; no B channel, no AR ready).
interface axi_intf
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
        input  awready, wready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
        output awready, wready, rdata, rvalid
    );

endinterface

// File: rtl/axi_ram_slave_ram_1r1w.sv
// Synchronous 1R1W word array with byte enables; storage is never reset.
// AXI_RAM_FWD_EN: a same-edge read of the word being written returns the merged (write-first) value.
module ram_1r1w #(
    parameter  int DEPTH_WORDS = 1024,
    parameter  int DATA_WIDTH  = 32,
    localparam int IDX_W       = $clog2(DEPTH_WORDS),
    localparam int STRB_W      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [STRB_W-1:0]     wbe_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wbe_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

`ifdef AXI_RAM_FWD_EN
    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wbe_i[i]) rdata_d[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end
`else
    always_comb begin
        rdata_d = mem_q[raddr_i];
    end
`endif

    // Output register loads only on a read so the value holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI-lite RAM responder: independent AW/W capture with a deferred commit, single-cycle read FSM.
// Optional AXI_RAM_FWD_EN selects write-first behaviour on same-word read/commit collisions.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH  = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH  = AXI_DATA_WIDTH,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic   clk,
    input  logic   rst_n,
    axi_intf.slave axi
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr_w;
    logic [ADDR_WIDTH-1:0] araddr_w;
    logic                  unused_addr;

    logic                  aw_pending_q, aw_pending_d;
    logic                  w_pending_q,  w_pending_d;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  commit;
    logic                  aw_hs;
    logic                  w_hs;

    r_state_e              r_state_q, r_state_d;
    logic                  rd_en;

    assign awaddr_w    = axi.awaddr;
    assign araddr_w    = axi.araddr;
    assign unused_addr = ^{awaddr_w, araddr_w};

    assign axi.awready = !aw_pending_q;
    assign axi.wready  = !w_pending_q;
    assign aw_hs       = axi.awvalid && !aw_pending_q;
    assign w_hs        = axi.wvalid && !w_pending_q;
    // Commit only once both halves are already held; readies are low on that edge.
    assign commit      = aw_pending_q && w_pending_q;

    always_comb begin
        aw_pending_d = aw_pending_q;
        w_pending_d  = w_pending_q;
        if (commit) begin
            aw_pending_d = 1'b0;
            w_pending_d  = 1'b0;
        end else begin
            if (aw_hs) aw_pending_d = 1'b1;
            if (w_hs)  w_pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_pending_q <= 1'b0;
            w_pending_q  <= 1'b0;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            aw_pending_q <= aw_pending_d;
            w_pending_q  <= w_pending_d;
            if (aw_hs) aw_idx_q <= awaddr_w[IDX_W+1:2];
            if (w_hs) begin
                wdata_q <= axi.wdata;
                wstrb_q <= axi.wstrb;
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (axi.arvalid) begin
                    rd_en     = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state_q <= R_IDLE;
        else        r_state_q <= r_state_d;
    end

    assign axi.rvalid = (r_state_q == R_DATA);

    ram_1r1w #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit),
        .waddr_i (aw_idx_q),
        .wbe_i   (wstrb_q),
        .wdata_i (wdata_q),
        .re_i    (rd_en),
        .raddr_i (araddr_w[IDX_W+1:2]),
        .rdata_o (axi.rdata)
    );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: write ordering, strobes, backpressure, collision, reset, aliasing.
module tb_axi_ram_slave;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

`ifdef AXI_RAM_FWD_EN
    localparam logic [31:0] COLL_EXP = 32'hCAFEF00D;
`else
    localparam logic [31:0] COLL_EXP = 32'h0000_0000;
`endif

    axi_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_ram_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        step();
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic vld);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        step();
        bus.arvalid = 1'b0;
        vld  = bus.rvalid;
        data = bus.rdata;
        step();
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        #2;
        n_checks++; if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL reset_awready got %b want 1", bus.awready); end
        n_checks++; if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %b want 1", bus.wready); end
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_aw_then_w();
        logic [31:0] d;
        logic        v;
        bus.awaddr  = 32'h10;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL awfirst_awready_c2 got %b want 0", bus.awready); end
        step();
        n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL awfirst_awready_c3 got %b want 0", bus.awready); end
        n_checks++; if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL awfirst_wready_c3 got %b want 1", bus.wready); end
        bus.wdata  = 32'hDEADBEEF;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        n_checks++; if ({bus.awready, bus.wready} !== 2'b00) begin n_fail++; $display("FAIL awfirst_ready_c4 got %b want 00", {bus.awready, bus.wready}); end
        step();
        n_checks++; if ({bus.awready, bus.wready} !== 2'b11) begin n_fail++; $display("FAIL awfirst_ready_c5 got %b want 11", {bus.awready, bus.wready}); end
        do_read(32'h10, d, v);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL awfirst_rvalid got %b want 1", v); end
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL awfirst_rdata got %h want deadbeef", d); end
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL awfirst_rvalid_drop got %b want 0", bus.rvalid); end
    endtask

    task automatic test_w_then_aw();
        logic [31:0] d;
        logic        v;
        bus.wdata  = 32'h12345678;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        n_checks++; if ({bus.awready, bus.wready} !== 2'b10) begin n_fail++; $display("FAIL wfirst_ready_pend got %b want 10", {bus.awready, bus.wready}); end
        bus.awaddr  = 32'h14;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        n_checks++; if ({bus.awready, bus.wready} !== 2'b00) begin n_fail++; $display("FAIL wfirst_ready_both got %b want 00", {bus.awready, bus.wready}); end
        step();
        n_checks++; if ({bus.awready, bus.wready} !== 2'b11) begin n_fail++; $display("FAIL wfirst_ready_done got %b want 11", {bus.awready, bus.wready}); end
        do_read(32'h14, d, v);
        n_checks++; if (d !== 32'h12345678 || v !== 1'b1) begin n_fail++; $display("FAIL wfirst_rdata got %h/%b want 12345678/1", d, v); end

        bus.awaddr  = 32'h18;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h0BADCAFE;
        bus.wvalid  = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n_checks++; if ({bus.awready, bus.wready} !== 2'b00) begin n_fail++; $display("FAIL same_ready_pend got %b want 00", {bus.awready, bus.wready}); end
        step();
        n_checks++; if ({bus.awready, bus.wready} !== 2'b11) begin n_fail++; $display("FAIL same_ready_done got %b want 11", {bus.awready, bus.wready}); end
        do_read(32'h18, d, v);
        n_checks++; if (d !== 32'h0BADCAFE) begin n_fail++; $display("FAIL same_rdata got %h want 0badcafe", d); end
        do_read(32'h14, d, v);
        n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL same_neighbour got %h want 12345678", d); end
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        logic        v;
        do_write(32'h20, 32'h11223344, 4'hF);
        do_write(32'h20, 32'hAABBCCDD, 4'h5);
        do_read(32'h20, d, v);
        n_checks++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb5_rdata got %h want 11bb33dd", d); end
        do_write(32'h20, 32'hFFFFFFFF, 4'h0);
        n_checks++; if ({bus.awready, bus.wready} !== 2'b11) begin n_fail++; $display("FAIL strb0_ready got %b want 11", {bus.awready, bus.wready}); end
        do_read(32'h20, d, v);
        n_checks++; if (d !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb0_rdata got %h want 11bb33dd", d); end
    endtask

    task automatic test_backpressure();
        bus.araddr  = 32'h20;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        step();
        // Moving araddr while arvalid stays high must not disturb the held beat.
        bus.araddr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h11BB33DD) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got %b/%h want 1/11bb33dd", i, bus.rvalid, bus.rdata);
            end
            step();
        end
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n_checks++; if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL bp_pre_hs got %b want 1", bus.rvalid); end
        step();
        bus.rready = 1'b0;
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_post_hs got %b want 0", bus.rvalid); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic        v;
        do_write(32'h30, 32'h0, 4'hF);
        bus.awaddr  = 32'h30;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'hCAFEF00D;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.araddr  = 32'h30;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        step();
        bus.arvalid = 1'b0;
        n_checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== COLL_EXP) begin n_fail++; $display("FAIL coll_rdata got %b/%h want 1/%h", bus.rvalid, bus.rdata, COLL_EXP); end
        step();
        bus.rready = 1'b0;
        do_read(32'h30, d, v);
        n_checks++; if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL coll_after got %h want cafef00d", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        do_write(32'h40, 32'h01020304, 4'hF);
        bus.awaddr  = 32'h40;
        bus.awvalid = 1'b1;
        bus.araddr  = 32'h20;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        step();
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        n_checks++; if (bus.awready !== 1'b0 || bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b/%b want 0/1", bus.awready, bus.rvalid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid got %b want 0", bus.rvalid); end
        n_checks++; if ({bus.awready, bus.wready} !== 2'b11) begin n_fail++; $display("FAIL rstmid_ready got %b want 11", {bus.awready, bus.wready}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        // A lone W after reset must not pair with the discarded AW.
        bus.wdata  = 32'hEEEEEEEE;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        n_checks++; if ({bus.awready, bus.wready} !== 2'b10) begin n_fail++; $display("FAIL rstmid_wonly got %b want 10", {bus.awready, bus.wready}); end
        step();
        do_read(32'h40, d, v);
        n_checks++; if (d !== 32'h01020304) begin n_fail++; $display("FAIL rstmid_nowrite got %h want 01020304", d); end
        bus.awaddr  = 32'h44;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        step();
        do_read(32'h44, d, v);
        n_checks++; if (d !== 32'hEEEEEEEE) begin n_fail++; $display("FAIL rstmid_pair got %h want eeeeeeee", d); end
    endtask

    task automatic test_alias();
        logic [31:0] d;
        logic        v;
        do_write(32'h1010, 32'h5A5AA5A5, 4'hF);
        do_read(32'h0010, d, v);
        n_checks++; if (d !== 32'h5A5AA5A5) begin n_fail++; $display("FAIL alias_1010 got %h want 5a5aa5a5", d); end
        do_read(32'h0013, d, v);
        n_checks++; if (d !== 32'h5A5AA5A5) begin n_fail++; $display("FAIL alias_lowbits got %h want 5a5aa5a5", d); end
        do_read(32'h14, d, v);
        n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL alias_neighbour got %h want 12345678", d); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_aw_then_w();
        test_w_then_aw();
        test_strobes();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
